// File: rtl/mips_instr_encoder.sv
`default_nettype none
// ============================================================================
// mips_instr_encoder : assembles symbolic ops into MIPS words and streams them
//                      sequentially into instruction memory (LI -> LUI/ORI)
// Revision: 1.0
// ============================================================================
module mips_instr_encoder #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [4:0]        op_code,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [31:0]       imm,
  input  logic [25:0]       target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              full,
  output logic              err
);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] START_ADDR = ADDR_W'(BASE_ADDR);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] EMIT2   = 2'd1;
  localparam logic [1:0] FULL_ST = 2'd2;

  logic [1:0]        state;
  logic [1:0]        next_state;
  logic [5:0]        func;
  logic [5:0]        iop;
  logic              shift_imm;
  logic [31:0]       word0;
  logic [31:0]       word1;
  logic [31:0]       pend_word;
  logic              two_word;
  logic              illegal;
  logic [ADDR_W-1:0] next_free;
  logic              accept;
  logic              slot_last;
  logic              overflow;
  logic              do_write;

  always_comb begin
    func = 6'h00;
    iop  = 6'h00;
    case (op_code)
      5'h00: func = 6'h20;
      5'h01: func = 6'h21;
      5'h02: func = 6'h22;
      5'h03: func = 6'h23;
      5'h04: func = 6'h24;
      5'h05: func = 6'h25;
      5'h06: func = 6'h26;
      5'h07: func = 6'h27;
      5'h08: func = 6'h2A;
      5'h09: func = 6'h2B;
      5'h0A: func = 6'h00;
      5'h0B: func = 6'h02;
      5'h0C: func = 6'h03;
      5'h0D: func = 6'h04;
      5'h0E: func = 6'h06;
      5'h0F: func = 6'h07;
      5'h10: iop  = 6'h23;
      5'h11: iop  = 6'h2B;
      5'h12: iop  = 6'h04;
      5'h13: iop  = 6'h05;
      5'h14: iop  = 6'h08;
      5'h15: iop  = 6'h09;
      5'h16: iop  = 6'h0C;
      5'h17: iop  = 6'h0D;
      5'h18: iop  = 6'h0E;
      5'h19: iop  = 6'h0A;
      5'h1A: iop  = 6'h0B;
      default: ;
    endcase
  end

  always_comb begin
    word0     = 32'h0;
    word1     = 32'h0;
    two_word  = 1'b0;
    illegal   = 1'b0;
    shift_imm = (op_code == 5'h0A) || (op_code == 5'h0B) || (op_code == 5'h0C);
    if (op_code < 5'h10) begin
      word0 = {6'h00, (shift_imm ? 5'd0 : rs), rt, rd, (shift_imm ? shamt : 5'd0), func};
    end else if (op_code <= 5'h1A) begin
      word0 = {iop, rs, rt, imm[15:0]};
    end else begin
      case (op_code)
        5'h1B: word0 = {6'h02, target};
        5'h1C: word0 = {6'h0F, 5'd0, rt, imm[15:0]};
        5'h1D: begin
          // LI collapses to a single ORI or LUI whenever one half is zero
          if (imm[31:16] == 16'h0) begin
            word0 = {6'h0D, 5'd0, rt, imm[15:0]};
          end else begin
            word0 = {6'h0F, 5'd0, rt, imm[31:16]};
            if (imm[15:0] != 16'h0) begin
              two_word = 1'b1;
              word1    = {6'h0D, rt, rt, imm[15:0]};
            end
          end
        end
        5'h1E:   word0   = 32'h0;
        default: illegal = 1'b1;
      endcase
    end
  end

  // imem_addr shows the slot being written, or the next free slot when idle
  assign next_free = (imem_we && (state != FULL_ST)) ? imem_addr + 1'b1 : imem_addr;
  assign slot_last = (next_free == LAST_ADDR);
  assign accept    = op_valid && op_ready;
  assign overflow  = accept && !illegal && two_word && slot_last;
  assign do_write  = (state == EMIT2) || (accept && !illegal && !overflow);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    if (clear) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (accept && !illegal && !overflow) begin
            if (two_word) begin
              next_state = EMIT2;
            end else if (slot_last) begin
              next_state = FULL_ST;
            end
          end
        end
        EMIT2:   next_state = slot_last ? FULL_ST : IDLE;
        FULL_ST: next_state = FULL_ST;
        default: next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    op_ready = (state == IDLE) && !clear;
    full     = (state == FULL_ST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      imem_we    <= 1'b0;
      imem_addr  <= START_ADDR;
      imem_wdata <= 32'h0;
      err        <= 1'b0;
      pend_word  <= 32'h0;
    end else if (clear) begin
      imem_we    <= 1'b0;
      imem_addr  <= START_ADDR;
      err        <= 1'b0;
    end else begin
      imem_we    <= do_write;
      imem_addr  <= next_free;
      err        <= accept && (illegal || overflow);
      if (do_write) begin
        imem_wdata <= (state == EMIT2) ? pend_word : word0;
      end
      if (accept && two_word) begin
        pend_word <= word1;
      end
    end
  end

endmodule
`default_nettype wire
